// File: rtl/circle_pkg.sv
// Shared types and constants for the circle draw controller.
// Latency: n/a; backpressure: n/a (definitions only).
package circle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR_INIT,
    CLR,
    CIRC_INIT,
    CHECK,
    OCT,
    UPDATE,
    DONE
  } state_t;

  localparam logic [4:0] SEL_UPDATE = 5'd0;
  localparam int         NUM_OCT    = 8;
  localparam int         SCREEN_W   = 160;
  localparam int         SCREEN_H   = 120;

endpackage

// File: rtl/circle_ctrl.sv
// Circle draw controller: optional full-screen clear (CIRCLE_CLEAR_EN) then midpoint circle, eight octant pixels per step.
// Outputs are Moore-decoded from the state register; start is only sampled in IDLE.
module circle_ctrl
  import circle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] colour_in,
  input  logic       xdone,
  input  logic       ydone,
  input  logic       cdone,
  input  logic       crit_pos,
  output logic       initx,
  output logic       inity,
  output logic       initc,
  output logic       loadx,
  output logic       loady,
  output logic       loadc,
  output logic [4:0] selx,
  output logic [4:0] sely,
  output logic       flagc,
  output logic       plot,
  output logic [2:0] colour,
  output logic       done
);

  state_t     state_q, state_d;
  logic [3:0] oct_q, oct_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      oct_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      oct_q   <= oct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    oct_d   = oct_q;
    initx   = 1'b0;
    inity   = 1'b0;
    initc   = 1'b0;
    loadx   = 1'b0;
    loady   = 1'b0;
    loadc   = 1'b0;
    selx    = SEL_UPDATE;
    sely    = SEL_UPDATE;
    flagc   = 1'b0;
    plot    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        oct_d = 4'd0;
        if (start) begin
`ifdef CIRCLE_CLEAR_EN
          state_d = CLR_INIT;
`else
          state_d = CIRC_INIT;
`endif
        end
      end
`ifdef CIRCLE_CLEAR_EN
      CLR_INIT: begin
        initx   = 1'b1;
        inity   = 1'b1;
        loadx   = 1'b1;
        loady   = 1'b1;
        state_d = CLR;
      end
      CLR: begin
        // One pixel per cycle; end of row wraps x and steps y in the same cycle.
        plot  = 1'b1;
        loadx = 1'b1;
        if (xdone) begin
          initx = 1'b1;
          loady = 1'b1;
        end
        if (xdone && ydone) state_d = CIRC_INIT;
      end
`endif
      CIRC_INIT: begin
        initx   = 1'b1;
        inity   = 1'b1;
        initc   = 1'b1;
        loadx   = 1'b1;
        loady   = 1'b1;
        loadc   = 1'b1;
        flagc   = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        flagc = 1'b1;
        if (cdone) begin
          state_d = DONE;
        end else begin
          state_d = OCT;
          oct_d   = 4'd1;
        end
      end
      OCT: begin
        plot  = 1'b1;
        flagc = 1'b1;
        selx  = {1'b0, oct_q};
        sely  = {1'b0, oct_q};
        if (oct_q == 4'(NUM_OCT)) begin
          state_d = UPDATE;
          oct_d   = 4'd0;
        end else begin
          oct_d = oct_q + 4'd1;
        end
      end
      UPDATE: begin
        // crit_pos decides whether offset_x steps inward this iteration.
        flagc   = 1'b1;
        loady   = 1'b1;
        loadc   = 1'b1;
        loadx   = crit_pos;
        state_d = CHECK;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        oct_d   = 4'd0;
      end
    endcase
  end

  assign colour = flagc ? colour_in : 3'b000;

`ifndef CIRCLE_CLEAR_EN
  logic unused_clr;
  assign unused_clr = xdone & ydone;
`endif

endmodule

// File: tb/tb_circle_ctrl.sv
// Self-checking bench for circle_ctrl with a behavioural pixel/circle datapath.
module tb_circle_ctrl;
  import circle_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] colour_in;
  logic       xdone, ydone, cdone, crit_pos;
  logic       initx, inity, initc, loadx, loady, loadc;
  logic [4:0] selx, sely;
  logic       flagc, plot, done;
  logic [2:0] colour;

  int checks   = 0;
  int failures = 0;

  localparam int CLR_PIX = SCREEN_W * SCREEN_H;

  circle_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .colour_in(colour_in),
    .xdone(xdone), .ydone(ydone), .cdone(cdone), .crit_pos(crit_pos),
    .initx(initx), .inity(inity), .initc(initc),
    .loadx(loadx), .loady(loady), .loadc(loadc),
    .selx(selx), .sely(sely), .flagc(flagc), .plot(plot),
    .colour(colour), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] outs;
  assign outs = {initx, inity, initc, loadx, loady, loadc, selx, sely, flagc, plot, colour, done};

  // Behavioural datapath: screen counters for clear, midpoint registers for the circle.
  int xcnt = 0, ycnt = 0, ox = 0, oy = 0, crit = 0;
  int radius = 4;

  always @(posedge clk) begin
    if (initc) begin
      ox   <= radius;
      oy   <= 0;
      crit <= 1 - radius;
    end else if (loadc) begin
      if (loadx) begin
        ox   <= ox - 1;
        oy   <= oy + 1;
        crit <= crit + 2 * ((oy + 1) - (ox - 1)) + 1;
      end else begin
        oy   <= oy + 1;
        crit <= crit + 2 * (oy + 1) + 1;
      end
    end else begin
      if (initx) xcnt <= 0;
      else if (loadx) xcnt <= xcnt + 1;
      if (inity) ycnt <= 0;
      else if (loady) ycnt <= ycnt + 1;
    end
  end

  assign xdone    = (xcnt == SCREEN_W - 1);
  assign ydone    = (ycnt == SCREEN_H - 1);
  assign cdone    = (oy > ox);
  assign crit_pos = (crit > 0);

  typedef struct packed {
    logic [4:0] sel;
    logic [2:0] col;
    logic       flagc;
  } pix_t;

  pix_t pix_q[$];
  logic upd_q[$];

  // Reference midpoint algorithm: queues the expected octant pixels and loadx decisions.
  task automatic push_circle(input int r, input logic [2:0] col);
    int x, y, c;
    x = r; y = 0; c = 1 - r;
    while (y <= x) begin
      for (int o = 1; o <= NUM_OCT; o++) pix_q.push_back('{sel: 5'(o), col: col, flagc: 1'b1});
      upd_q.push_back(c > 0);
      y++;
      if (c > 0) begin
        x--;
        c = c + 2 * (y - x) + 1;
      end else begin
        c = c + 2 * y + 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    colour_in = 3'b111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 22'd0) begin
        failures++;
        $display("FAIL reset_outs cycle=%0d got=%h exp=%h", i, outs, 22'd0);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 22'd0) begin
      failures++;
      $display("FAIL idle_outs got=%h exp=%h", outs, 22'd0);
    end
  endtask

  task automatic test_draw_hold();
    logic [21:0] exp_circ_init;
    pix_t e;
    logic eu;
    int   clr_run, circ_plots, upds;
    bit   prev_clr, seen_done;
    colour_in = 3'b010;
    radius = 4;
    exp_circ_init = {6'b111111, 5'd0, 5'd0, 1'b1, 1'b0, 3'b010, 1'b0};
`ifdef CIRCLE_CLEAR_EN
    for (int i = 0; i < CLR_PIX; i++) pix_q.push_back('{sel: 5'd0, col: 3'd0, flagc: 1'b0});
`endif
    push_circle(4, 3'b010);
    start = 1'b1;
    @(negedge clk);
    checks++;
`ifdef CIRCLE_CLEAR_EN
    if (outs !== {6'b110110, 16'd0}) begin
      failures++;
      $display("FAIL clr_init got=%h exp=%h", outs, {6'b110110, 16'd0});
    end
`else
    if (outs !== exp_circ_init) begin
      failures++;
      $display("FAIL circ_init got=%h exp=%h", outs, exp_circ_init);
    end
`endif
    clr_run = 0; circ_plots = 0; upds = 0; prev_clr = 0; seen_done = 0;
    for (int c = 0; c < 25000 && !seen_done; c++) begin
      if (c > 0) @(negedge clk);
      if (plot) begin
        checks++;
        if (pix_q.size() == 0) begin
          failures++;
          $display("FAIL extra_plot sel=%0d colour=%0d flagc=%0d", selx, colour, flagc);
        end else begin
          e = pix_q.pop_front();
          if ({selx, sely, colour, flagc} !== {e.sel, e.sel, e.col, e.flagc}) begin
            failures++;
            $display("FAIL pixel got sel=%0d/%0d col=%0d flagc=%0d exp sel=%0d col=%0d flagc=%0d",
                     selx, sely, colour, flagc, e.sel, e.col, e.flagc);
          end
        end
        if (flagc) circ_plots++;
      end
`ifdef CIRCLE_CLEAR_EN
      if (plot && !flagc) begin
        clr_run++;
      end else if (prev_clr) begin
        checks++;
        if (clr_run != CLR_PIX || outs !== exp_circ_init) begin
          failures++;
          $display("FAIL clear_run got=%0d outs=%h exp=%0d outs=%h", clr_run, outs, CLR_PIX, exp_circ_init);
        end
      end
      prev_clr = plot && !flagc;
`endif
      if (loadc && !initc) begin
        checks++;
        upds++;
        if (upd_q.size() == 0) begin
          failures++;
          $display("FAIL extra_update loadx=%0d", loadx);
        end else begin
          eu = upd_q.pop_front();
          if (loadx !== eu) begin
            failures++;
            $display("FAIL update_loadx idx=%0d got=%0d exp=%0d", upds, loadx, eu);
          end
        end
      end
      if (done) seen_done = 1;
    end
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL done_timeout got=0 exp=1");
    end
    checks++;
    if (circ_plots != 32 || upds != 4) begin
      failures++;
      $display("FAIL circle_counts got plots=%0d updates=%0d exp plots=32 updates=4", circ_plots, upds);
    end
    checks++;
    if (pix_q.size() != 0 || upd_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got pix=%0d upd=%0d exp 0 0", pix_q.size(), upd_q.size());
    end
    pix_q.delete();
    upd_q.delete();
    // start still high: must stay in DONE without restarting.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 22'd1) begin
        failures++;
        $display("FAIL done_hold cycle=%0d got=%h exp=%h", i, outs, 22'd1);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 22'd0) begin
      failures++;
      $display("FAIL done_to_idle got=%h exp=%h", outs, 22'd0);
    end
  endtask

  task automatic test_abort();
    logic [21:0] exp_first;
    bit found;
    colour_in = 3'b101;
    radius = 4;
`ifdef CIRCLE_CLEAR_EN
    exp_first = {6'b110110, 16'd0};
`else
    exp_first = {6'b111111, 5'd0, 5'd0, 1'b1, 1'b0, 3'b101, 1'b0};
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (outs !== exp_first) begin
      failures++;
      $display("FAIL abort_first got=%h exp=%h", outs, exp_first);
    end
    found = 0;
    for (int c = 0; c < 25000 && !found; c++) begin
      @(negedge clk);
      if (plot && flagc && selx == 5'd5) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL oct5_timeout got=0 exp=1");
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 22'd0) begin
      failures++;
      $display("FAIL abort_idle got=%h exp=%h", outs, 22'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== exp_first) begin
      failures++;
      $display("FAIL restart got=%h exp=%h", outs, exp_first);
    end
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 22'd0) begin
      failures++;
      $display("FAIL final_idle got=%h exp=%h", outs, 22'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    colour_in = 3'b000;
    test_reset();
    test_draw_hold();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/circle_ctrl.md
CIRCLE_CTRL -- requirements
Module: circle_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request a draw; sampled only in IDLE.
REQ-004 colour_in  input  3  circle pixel colour.
REQ-005 xdone  input  1  datapath x counter at last column (159).
REQ-006 ydone  input  1  datapath y counter at last row (119).
REQ-007 cdone  input  1  datapath circle loop finished (offset_y > offset_x).
REQ-008 crit_pos  input  1  datapath crit register > 0.
REQ-009 initx, inity, initc  output  1 each  datapath register initialise strobes.
REQ-010 loadx, loady, loadc  output  1 each  datapath register load enables.
REQ-011 selx, sely  output  5 each  datapath pixel source code: 0 = counter/update, 1..8 = octant n.
REQ-012 flagc  output  1  datapath mode: 0 = clear-screen, 1 = circle.
REQ-013 plot  output  1  pixel write enable, one pixel per asserted cycle.
REQ-014 colour  output  3  pixel colour: 3'b000 during clear, colour_in during circle.
REQ-015 done  output  1  draw complete.

Function
REQ-016 States SHALL be IDLE, CLR_INIT, CLR, CIRC_INIT, CHECK, OCT, UPDATE, DONE.
REQ-017 IDLE: all outputs 0; start=1 -> CLR_INIT (or CIRC_INIT when clear is compiled out).
REQ-018 CLR_INIT: initx=inity=loadx=loady=1, flagc=0, plot=0; next CLR.
REQ-019 CLR: plot=1, flagc=0, loadx=1; if xdone also initx=1, loady=1; xdone&&ydone -> CIRC_INIT, else stay.
REQ-020 Clear SHALL produce exactly 19200 plot cycles (160x120), no gaps.
REQ-021 CIRC_INIT: initx=inity=initc=loadx=loady=loadc=1, flagc=1, plot=0; next CHECK.
REQ-022 CHECK: plot=0; cdone=1 -> DONE, else OCT with octant counter=1.
REQ-023 OCT: plot=1, flagc=1, selx=sely=octant counter; counter steps 1..8, one per cycle; after 8 -> UPDATE.
REQ-024 UPDATE: loady=1, loadc=1, loadx=crit_pos, sel=0, plot=0; next CHECK.
REQ-025 crit_pos SHALL be sampled in the UPDATE cycle only; other cycles ignore it.
REQ-026 DONE: done=1, all strobes 0; stays until start=0, then IDLE.
REQ-027 start SHALL be ignored in every state except IDLE; start held high after DONE SHALL NOT retrigger.
REQ-028 Outputs SHALL be Moore-decoded from state, octant counter, and xdone/ydone/crit_pos per above; no combinational path from start to any output.
REQ-029 colour SHALL be 3'b000 whenever flagc=0, colour_in whenever flagc=1.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, octant counter=0, all outputs 0 in the following cycle, from any state.
REQ-031 reset SHALL override start in the same cycle.

Configuration
REQ-032 CIRCLE_CLEAR_EN defined: IDLE -> CLR_INIT and clear phase present.
REQ-033 CIRCLE_CLEAR_EN undefined: CLR_INIT/CLR absent, IDLE -> CIRC_INIT directly, no flagc=0 plot cycles ever.

Structure
REQ-034 Package circle_pkg SHALL hold the state enum, SEL_UPDATE=5'd0, NUM_OCT=8, SCREEN_W=160, SCREEN_H=120.
REQ-035 Single flat module; no sub-module (octant counter inline).

Verification
REQ-036 reset for 2 cycles -> all outputs 0, done=0; start ignored while reset=1.
REQ-037 CLEAR_EN, start pulse -> CLR_INIT one cycle, then exactly 19200 plot cycles with colour=0, then initc=1 one cycle.
REQ-038 Behavioural datapath, radius 4, colour_in=3'b010 -> 4 loop iterations, 32 plot cycles with sel sequence 1..8 repeated, colour=3'b010, then done=1.
REQ-039 Radius 4 UPDATE cycles -> loadx pattern 0,0,1,1 matching crit_pos.
REQ-040 reset during 5th OCT cycle -> next cycle IDLE, plot=0; fresh start restarts from CLR_INIT.
REQ-041 start held high through completion -> done stays 1, no new CLR_INIT; start low -> IDLE next cycle; without CLEAR_EN, start -> initc=1 next cycle.
